// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and defaults shared by the UART transmitter blocks.
// The UART_ADDR decode constant lives in 99_define.vh, not here.
package uart_pkg;

  localparam int unsigned UART_DEFAULT_CLKS_PER_BIT = 868;
  localparam int unsigned UART_DATA_W               = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_state_e;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO with occupancy counter and sticky drop flag.
// Writes while full are accepted only if a pop happens in the same cycle.
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd,
  output logic [WIDTH-1:0]         rd_data_c,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_nxt_c,
  output logic                     overflow
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  // A pop never happens on an empty FIFO; a full FIFO still accepts a write alongside a pop.
  assign rd_ok     = rd & ~empty;
  assign wr_ok     = wr & (~full | rd_ok);
  assign rd_data_c = mem[rd_ptr];

  // Next occupancy: simultaneous push and pop cancel out.
  always_comb begin
    count_nxt_c = count;
    if (wr_ok && !rd_ok) begin
      count_nxt_c = count + CNT_W'(1);
    end else if (rd_ok && !wr_ok) begin
      count_nxt_c = count - CNT_W'(1);
    end
  end

  // Storage array, written only on an accepted push.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers, occupancy, flags; reset discards all contents.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (rd_ok) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count_nxt_c;
      full  <= (count_nxt_c == CNT_W'(DEPTH));
      empty <= (count_nxt_c == '0);
      if (wr && !wr_ok) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter fed by CPU stores.
// Bytes queue in sync_fifo and leave as 8N1 frames, or 8E1 when
// UART_TX_PARITY_EN is defined.
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT,
  parameter int unsigned DEPTH        = 16
) (
  input  logic                   sys_clk_i,
  input  logic                   sys_rstn_i,
  input  logic                   uart_wr_i,
  input  logic [7:0]             uart_dat_i,
  output logic                   uart_tx,
  output logic                   full_o,
  output logic                   busy_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   overflow_o
);

  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;

  uart_state_e       state_q;
  uart_state_e       state_d;
  logic [BAUD_W-1:0] baud_q;
  logic [BAUD_W-1:0] baud_d;
  logic [2:0]        bit_q;
  logic [2:0]        bit_d;
  logic [7:0]        shift_q;
  logic [7:0]        shift_d;
`ifdef UART_TX_PARITY_EN
  logic              parity_q;
  logic              parity_d;
`endif
  logic              tx_d;
  logic              busy_d;
  logic              pop_c;
  logic              bit_end_c;
  logic              fifo_empty;
  logic [7:0]        fifo_dout_c;
  logic [CNT_W-1:0]  fifo_count_nxt_c;

  // Byte queue between the store path and the serializer.
  sync_fifo #(
    .WIDTH (UART_DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (sys_clk_i),
    .rst_n       (sys_rstn_i),
    .wr          (uart_wr_i),
    .wr_data     (uart_dat_i),
    .rd          (pop_c),
    .rd_data_c   (fifo_dout_c),
    .full        (full_o),
    .empty       (fifo_empty),
    .count       (count_o),
    .count_nxt_c (fifo_count_nxt_c),
    .overflow    (overflow_o)
  );

  // Next-state, baud/bit counters, pop request and next line level.
  always_comb begin
    state_d   = state_q;
    baud_d    = baud_q + BAUD_W'(1);
    bit_d     = bit_q;
    shift_d   = shift_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    pop_c     = 1'b0;
    bit_end_c = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));
    tx_d      = 1'b1;
    busy_d    = 1'b0;

    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!fifo_empty) begin
          pop_c    = 1'b1;
          shift_d  = fifo_dout_c;
`ifdef UART_TX_PARITY_EN
          parity_d = ^fifo_dout_c;
`endif
          state_d  = START;
        end
      end
      START: begin
        if (bit_end_c) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (bit_end_c) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end_c) begin
          baud_d  = '0;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (bit_end_c) begin
          baud_d = '0;
          // Chain straight into the next frame when a byte is waiting.
          if (!fifo_empty) begin
            pop_c    = 1'b1;
            shift_d  = fifo_dout_c;
`ifdef UART_TX_PARITY_EN
            parity_d = ^fifo_dout_c;
`endif
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        baud_d  = '0;
        state_d = IDLE;
      end
    endcase

    // Line level registered from the state being entered.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase

    busy_d = (state_d != IDLE) || (fifo_count_nxt_c != '0);
  end

  // Serializer state and registered outputs; reset forces the line high at once.
  always_ff @(posedge sys_clk_i or negedge sys_rstn_i) begin
    if (!sys_rstn_i) begin
      state_q  <= IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
      uart_tx  <= 1'b1;
      busy_o   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
      uart_tx  <= tx_d;
      busy_o   <= busy_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed stimulus with a frame-decoding scoreboard monitor.
module tb_uart_tx_fifo;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       clk  = 1'b0;
  logic       rstn = 1'b0;
  logic       wr   = 1'b0;
  logic [7:0] dat  = 8'h00;
  logic       tx;
  logic       full;
  logic       busy;
  logic [2:0] count;
  logic       overflow;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  logic [7:0] exp_q[$];
  int         starts[$];
  int         frames = 0;

  uart_tx_fifo #(
    .CLKS_PER_BIT (CPB),
    .DEPTH        (DEPTH)
  ) dut (
    .sys_clk_i  (clk),
    .sys_rstn_i (rstn),
    .uart_wr_i  (wr),
    .uart_dat_i (dat),
    .uart_tx    (tx),
    .full_o     (full),
    .busy_o     (busy),
    .count_o    (count),
    .overflow_o (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Frame monitor: finds each start edge, samples bit centres, pops the scoreboard.
  logic          prev_tx    = 1'b1;
  bit            mon_active = 1'b0;
  int            mon_pos    = 0;
  logic [FB-1:0] bits       = '0;
  logic          mon_par    = 1'b0;

  always @(negedge clk) begin
    logic [7:0] data;
    int         e;
    if (!rstn) begin
      mon_active = 1'b0;
    end else if (!mon_active) begin
      if (prev_tx && !tx) begin
        mon_active = 1'b1;
        mon_pos    = 0;
        starts.push_back(cyc);
      end
    end else begin
      mon_pos++;
    end
    if (mon_active && (mon_pos % CPB) == 2) begin
      bits[mon_pos / CPB] = tx;
      if (mon_pos / CPB == FB - 1) begin
        mon_active = 1'b0;
        frames++;
        data = bits[8:1];
        e    = -1;
        if (exp_q.size() > 0) e = int'(exp_q.pop_front());
        chk("start_bit", int'(bits[0]), 0);
        chk("frame_data", int'(data), e);
`ifdef UART_TX_PARITY_EN
        mon_par = bits[9];
        chk("parity_bit", int'(bits[9]), int'(^data));
`endif
        chk("stop_bit", int'(bits[FB-1]), 1);
      end
    end
    prev_tx = tx;
  end

  task automatic wait_idle(input int bound, input string name);
    int n = 0;
    while (!(busy == 1'b0 && !mon_active && exp_q.size() == 0) && n < bound) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(n < bound), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  k;
    int  f0;
    int  s0;
    bit  low_seen;
    logic [7:0] burst [4];
    burst[0] = 8'hA5; burst[1] = 8'h3C; burst[2] = 8'hFF; burst[3] = 8'h00;

    // Reset values and idle line
    repeat (3) @(negedge clk);
    chk("rst_tx", int'(tx), 1);
    chk("rst_count", int'(count), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_overflow", int'(overflow), 0);
    chk("rst_full", int'(full), 0);
    #1 rstn = 1'b1;
    low_seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (!tx) low_seen = 1'b1;
    end
    chk("idle_line_low", int'(low_seen), 0);

    // Single byte 0x55: latency and busy duration
    @(negedge clk);
    wr = 1'b1; dat = 8'h55; exp_q.push_back(8'h55); k = cyc + 1;
    @(negedge clk);
    wr = 1'b0;
    chk("single_count_stored", int'(count), 1);
    chk("single_busy_stored", int'(busy), 1);
    chk("single_tx_before_pop", int'(tx), 1);
    @(negedge clk);
    chk("single_count_popped", int'(count), 0);
    chk("single_tx_fall", int'(tx), 0);
    while (cyc < k + CPB * FB) @(negedge clk);
    chk("single_busy_last", int'(busy), 1);
    @(negedge clk);
    chk("single_busy_fall", int'(busy), 0);
    chk("single_start_cycle", starts[starts.size() - 1], k + 1);
    wait_idle(100, "single_drain");

    // Burst of four back-to-back writes
    f0 = frames; s0 = starts.size();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr = 1'b1; dat = burst[i]; exp_q.push_back(burst[i]);
    end
    @(negedge clk);
    wr = 1'b0;
    wait_idle(400, "burst_drain");
    chk("burst_frames", frames - f0, 4);
    if (starts.size() >= s0 + 4) begin
      for (int i = 0; i < 3; i++)
        chk("burst_gap", starts[s0 + i + 1] - starts[s0 + i], CPB * FB);
    end
    chk("burst_overflow", int'(overflow), 0);

    // Overflow: six writes into a depth-4 FIFO
    f0 = frames;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      if (i == 2) chk("ovf_count_first", int'(count), 1);
      if (i == 3) chk("ovf_count_push_pop_one", int'(count), 1);
      if (i == 6) begin
        chk("ovf_full_before_drop", int'(full), 1);
        chk("ovf_count_full", int'(count), 4);
        chk("ovf_flag_before_drop", int'(overflow), 0);
      end
      wr = 1'b1; dat = 8'(i);
      if (i <= 5) exp_q.push_back(8'(i));
    end
    @(negedge clk);
    wr = 1'b0;
    chk("ovf_flag_set", int'(overflow), 1);
    chk("ovf_count_after_drop", int'(count), 4);
    wait_idle(800, "ovf_drain");
    chk("ovf_frames", frames - f0, 5);
    chk("ovf_flag_sticky", int'(overflow), 1);
    @(negedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("ovf_flag_cleared", int'(overflow), 0);
    #1 rstn = 1'b1;

    // Write while full coinciding with a pop: accepted, count stays at DEPTH
    f0 = frames;
    @(negedge clk);
    k = cyc + 1;
    for (int i = 0; i < 5; i++) begin
      wr = 1'b1; dat = 8'(8'h11 + i); exp_q.push_back(8'(8'h11 + i));
      @(negedge clk);
    end
    wr = 1'b0;
    while (cyc < k + CPB * FB) @(negedge clk);
    chk("fullpop_count_before", int'(count), 4);
    wr = 1'b1; dat = 8'h16; exp_q.push_back(8'h16);
    @(negedge clk);
    wr = 1'b0;
    chk("fullpop_count_after", int'(count), 4);
    chk("fullpop_full_after", int'(full), 1);
    chk("fullpop_no_overflow", int'(overflow), 0);
    wait_idle(1200, "fullpop_drain");
    chk("fullpop_frames", frames - f0, 6);

    // Reset during DATA bit 3 of 0x0F with two bytes queued
    f0 = frames;
    @(negedge clk);
    wr = 1'b1; dat = 8'h0F; k = cyc + 1;
    @(negedge clk);
    dat = 8'hAA;
    @(negedge clk);
    dat = 8'hBB;
    @(negedge clk);
    wr = 1'b0;
    chk("abort_count_queued", int'(count), 2);
    while (cyc < k + 18) @(negedge clk);
    chk("abort_bit3_level", int'(tx), 1);
    #1 rstn = 1'b0;
    #1;
    chk("abort_tx_high", int'(tx), 1);
    chk("abort_count_zero", int'(count), 0);
    chk("abort_busy_zero", int'(busy), 0);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    repeat (100) @(negedge clk);
    chk("abort_no_frames", frames - f0, 0);
    chk("abort_count_after", int'(count), 0);

    // Reset during the start bit: line must return high before any clock edge
    @(negedge clk);
    wr = 1'b1; dat = 8'h12;
    @(negedge clk);
    wr = 1'b0;
    k = 0;
    while (tx && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("start_seen", int'(tx), 0);
    #1 rstn = 1'b0;
    #1;
    chk("async_tx_high", int'(tx), 1);
    repeat (2) @(negedge clk);
    #1 rstn = 1'b1;
    repeat (20) @(negedge clk);
    chk("async_count_after", int'(count), 0);

`ifdef UART_TX_PARITY_EN
    // Even parity: 0x07 has odd weight, 0x03 even
    @(negedge clk);
    wr = 1'b1; dat = 8'h07; exp_q.push_back(8'h07); k = cyc + 1;
    @(negedge clk);
    wr = 1'b0;
    while (cyc < k + 44) @(negedge clk);
    chk("par_busy_last", int'(busy), 1);
    @(negedge clk);
    chk("par_busy_fall", int'(busy), 0);
    wait_idle(100, "par07_drain");
    chk("par07_bit", int'(mon_par), 1);
    @(negedge clk);
    wr = 1'b1; dat = 8'h03; exp_q.push_back(8'h03);
    @(negedge clk);
    wr = 1'b0;
    wait_idle(100, "par03_drain");
    chk("par03_bit", int'(mon_par), 0);
`endif

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
